// File: rtl/pc_gen_if.sv
// pc_gen_if -- fetch-control bundle between a front-end sequencer and pc_gen.
//
// Handshake semantics: there is no valid/ready pair. Every control input is a
// level that pc_gen samples on each rising clk edge while ce=1. Every output
// is registered and changes only on that edge. While ce=0 the inputs are
// ignored.
//
// Signals (directions as seen from pc_gen, the slave):
//   stall, br, call, ret, trap   in   redirect / hold requests
//   br_addr, trap_vec            in   AW-bit targets
//   pc                           out  current fetch address
//   ce                           out  fetch enable
//   ras_empty                    out  return-address stack holds no entries
//   misalign, ras_underflow      out  one-cycle event pulses
//   dbg_state                    out  sequencer state (0 = idle, 1 = run)
interface pc_gen_if #(
    parameter int AW = 32
);
    logic          stall;
    logic          br;
    logic [AW-1:0] br_addr;
    logic          call;
    logic          ret;
    logic          trap;
    logic [AW-1:0] trap_vec;
    logic [AW-1:0] pc;
    logic          ce;
    logic          ras_empty;
    logic          misalign;
    logic          ras_underflow;
    logic          dbg_state;

    modport master (
        output stall, br, br_addr, call, ret, trap, trap_vec,
        input  pc, ce, ras_empty, misalign, ras_underflow, dbg_state
    );

    modport slave (
        input  stall, br, br_addr, call, ret, trap, trap_vec,
        output pc, ce, ras_empty, misalign, ras_underflow, dbg_state
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator with a return-address stack (RAS).
//
// Each cycle with ce=1 the next pc is chosen by strict priority:
// trap > br > ret (RAS non-empty) > stall > increment by STEP.
// A br with call=1 pushes pc+STEP in the same cycle as the redirect.
// The RAS is a circular buffer; pushing when full overwrites the oldest entry.
//
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous, active-high reset
//   bus  pc_gen_if.slave  control inputs and registered status outputs
module pc_gen #(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            STEP      = 4,
    parameter int            RAS_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    pc_gen_if.slave bus
);
    localparam int            PW         = $clog2(RAS_DEPTH);
    localparam int            CW         = $clog2(RAS_DEPTH + 1);
    localparam logic [AW-1:0] ALIGN_MASK = AW'(STEP - 1);
    localparam logic [AW-1:0] STEP_V     = AW'(STEP);
    localparam logic [CW-1:0] FULL_CNT   = CW'(RAS_DEPTH);

    // Two-state sequencer: idle during reset, run from the first edge after.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_n;
    logic [AW-1:0] pc_q, pc_n;
    logic [PW-1:0] top_q, top_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          mis_q, mis_n;
    logic          unf_q, unf_n;
    logic          push, pop, flush;
    logic [AW-1:0] ras_mem [RAS_DEPTH];

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (state_q == ST_IDLE) state_n = ST_RUN;
    end

    // ---------------- next-pc / RAS control ----------------
    always_comb begin
        pc_n  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        mis_n = 1'b0;
        unf_n = 1'b0;
        if (state_q == ST_RUN) begin
            if (bus.trap) begin
                pc_n  = bus.trap_vec;
                flush = 1'b1;
            end else if (bus.br) begin
                pc_n  = bus.br_addr & ~ALIGN_MASK;
                mis_n = |(bus.br_addr & ALIGN_MASK);
                push  = bus.call;
            end else if (bus.ret && (cnt_q != '0)) begin
                pc_n = ras_mem[top_q];
                pop  = 1'b1;
            end else begin
                // A ret that finds the stack empty degrades to hold/increment.
                unf_n = bus.ret;
                if (!bus.stall) pc_n = pc_q + STEP_V;
            end
        end
    end

    always_comb begin
        top_n = top_q;
        cnt_n = cnt_q;
        if (flush) begin
            cnt_n = '0;
        end else if (push) begin
            top_n = top_q + PW'(1);
            // When full the write lands on the oldest slot; count saturates.
            if (cnt_q != FULL_CNT) cnt_n = cnt_q + CW'(1);
        end else if (pop) begin
            top_n = top_q - PW'(1);
            cnt_n = cnt_q - CW'(1);
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            top_q <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_n;
            top_q <= top_n;
            cnt_q <= cnt_n;
            mis_q <= mis_n;
            unf_q <= unf_n;
        end
    end

    // Entry storage is not reset; it is unobservable while the count is zero.
    always_ff @(posedge clk) begin
        if (!rst && push) ras_mem[top_q + PW'(1)] <= pc_q + STEP_V;
    end

    assign bus.pc            = pc_q;
    assign bus.ce            = (state_q == ST_RUN);
    assign bus.ras_empty     = (cnt_q == '0);
    assign bus.misalign      = mis_q;
    assign bus.ras_underflow = unf_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed, table-driven bench for pc_gen (AW=32 instance) plus a
// short sequence on an AW=8 instance for address wrap.
module tb_pc_gen;
    logic clk;
    logic rst;
    logic rst8;

    pc_gen_if #(.AW(32)) bus ();
    pc_gen_if #(.AW(8))  bus8 ();

    pc_gen #(.AW(32), .RESET_VEC(32'h0), .STEP(4), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    pc_gen #(.AW(8), .RESET_VEC(8'hF0), .STEP(4), .RAS_DEPTH(2)) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic        call;
        logic        ret;
        logic        trap;
        logic [31:0] br_addr;
        logic [31:0] trap_vec;
        logic [31:0] e_pc;
        logic        e_empty;
        logic        e_mis;
        logic        e_unf;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic stall, input logic br, input logic call,
                                input logic ret, input logic trap,
                                input logic [31:0] br_addr, input logic [31:0] trap_vec,
                                input logic [31:0] e_pc, input logic e_empty,
                                input logic e_mis, input logic e_unf);
        vec_t v;
        v.stall = stall; v.br = br; v.call = call; v.ret = ret; v.trap = trap;
        v.br_addr = br_addr; v.trap_vec = trap_vec;
        v.e_pc = e_pc; v.e_empty = e_empty; v.e_mis = e_mis; v.e_unf = e_unf;
        vecs.push_back(v);
    endfunction

    task automatic drive_idle();
        bus.stall = 0; bus.br = 0; bus.call = 0; bus.ret = 0; bus.trap = 0;
        bus.br_addr = '0; bus.trap_vec = '0;
    endtask

    task automatic drive_idle8();
        bus8.stall = 0; bus8.br = 0; bus8.call = 0; bus8.ret = 0; bus8.trap = 0;
        bus8.br_addr = '0; bus8.trap_vec = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_ce,
                             input logic e_empty, input logic e_mis, input logic e_unf);
        chk({tag, "_pc"},  bus.pc,                   e_pc);
        chk({tag, "_ce"},  32'(bus.ce),              32'(e_ce));
        chk({tag, "_emp"}, 32'(bus.ras_empty),       32'(e_empty));
        chk({tag, "_mis"}, 32'(bus.misalign),        32'(e_mis));
        chk({tag, "_unf"}, 32'(bus.ras_underflow),   32'(e_unf));
    endtask

    task automatic apply(input int idx, input vec_t v);
        bus.stall = v.stall; bus.br = v.br; bus.call = v.call;
        bus.ret = v.ret; bus.trap = v.trap;
        bus.br_addr = v.br_addr; bus.trap_vec = v.trap_vec;
        step();
        check_all($sformatf("v%0d", idx), v.e_pc, 1'b1, v.e_empty, v.e_mis, v.e_unf);
    endtask

    // ---------------- test ----------------
    initial begin
        // Vector table: inputs sampled at one edge, outputs checked after it.
        //   stall br call ret trap  br_addr       trap_vec   e_pc        emp mis unf
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h4,        1,0,0);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h8,        1,0,0);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'hC,        1,0,0);
        add(1,0,0,0,0, 32'h0,          32'h0,  32'hC,        1,0,0);
        add(1,0,0,0,0, 32'h0,          32'h0,  32'hC,        1,0,0);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h10,       1,0,0);
        add(0,1,0,0,0, 32'h100,        32'h0,  32'h100,      1,0,0);
        add(0,1,1,0,0, 32'h200,        32'h0,  32'h200,      0,0,0);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h204,      0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h104,      1,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h108,      1,0,1);
        add(1,0,0,1,0, 32'h0,          32'h0,  32'h108,      1,0,1);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h10C,      1,0,0);
        add(0,1,1,0,0, 32'h400,        32'h0,  32'h400,      0,0,0);
        add(1,1,1,1,1, 32'h303,        32'h80, 32'h80,       1,0,0);
        add(1,1,0,0,0, 32'h40,         32'h0,  32'h40,       1,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h44,       1,0,1);
        add(0,1,0,0,0, 32'h203,        32'h0,  32'h200,      1,1,0);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h204,      1,0,0);
        add(0,1,1,0,0, 32'h500,        32'h0,  32'h500,      0,0,0);
        add(0,1,0,1,0, 32'h600,        32'h0,  32'h600,      0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h208,      1,0,0);
        add(0,1,1,0,0, 32'h1000,       32'h0,  32'h1000,     0,0,0);
        add(0,1,1,0,0, 32'h2000,       32'h0,  32'h2000,     0,0,0);
        add(0,1,1,0,0, 32'h3000,       32'h0,  32'h3000,     0,0,0);
        add(0,1,1,0,0, 32'h4000,       32'h0,  32'h4000,     0,0,0);
        add(0,1,1,0,0, 32'h5000,       32'h0,  32'h5000,     0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h4004,     0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h3004,     0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h2004,     0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h1004,     1,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h1008,     1,0,1);
        add(0,1,0,0,0, 32'hFFFFFFFC,   32'h0,  32'hFFFFFFFC, 1,0,0);
        add(0,0,0,0,0, 32'h0,          32'h0,  32'h0,        1,0,0);
        add(0,1,0,0,0, 32'hFFFFFFFC,   32'h0,  32'hFFFFFFFC, 1,0,0);
        add(0,1,1,0,0, 32'h10,         32'h0,  32'h10,       0,0,0);
        add(0,0,0,1,0, 32'h0,          32'h0,  32'h0,        1,0,0);

        // ---- reset block ----
        rst  = 1'b1;
        rst8 = 1'b1;
        drive_idle();
        drive_idle8();
        // Inputs are active during reset and must be ignored.
        bus.br = 1; bus.call = 1; bus.br_addr = 32'h900;
        step();
        step();
        check_all("rst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_idle();
        rst = 1'b0;
        step();
        check_all("rel", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // ---- reset during br+call ----
        bus.br = 1; bus.call = 1; bus.br_addr = 32'h700;
        rst = 1'b1;
        step();
        check_all("midrst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_idle();
        rst = 1'b0;
        step();
        check_all("midrel", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.ret = 1;
        step();
        check_all("midret", 32'h4, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_idle();

        // ---- AW=8 wrap ----
        rst8 = 1'b0;
        step();
        chk("w8_ce", 32'(bus8.ce), 32'd1);
        chk("w8_pc0", 32'(bus8.pc), 32'hF0);
        exp_q.push_back(8'hF4);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'hFC);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            step();
            chk("w8_inc", 32'(bus8.pc), 32'(e));
        end
        bus8.br = 1; bus8.br_addr = 8'h13;
        step();
        chk("w8_br_pc", 32'(bus8.pc), 32'h10);
        chk("w8_br_mis", 32'(bus8.misalign), 32'd1);
        drive_idle8();
        step();
        chk("w8_mis_clr", 32'(bus8.misalign), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
